// File: rtl/alu_operand_fwd_if.sv
// Operand-request, forwarding-network and resolved-operand signals for alu_operand_fwd.
// The master modport is the pipeline/testbench side; the slave modport is the forwarding unit.
interface alu_operand_fwd_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NSRC = 2,
  parameter int unsigned NFWD = 3,
  parameter int unsigned RAW  = 5
) ();
  localparam int unsigned SrcW = ($clog2(NFWD + 1) > 2) ? $clog2(NFWD + 1) : 2;

  logic                   in_valid;
  logic                   in_ready;
  logic [NSRC*RAW-1:0]    rs_addr;
  logic [NSRC*XLEN-1:0]   rf_data;
  logic [NFWD-1:0]        fwd_valid;
  logic [NFWD*RAW-1:0]    fwd_rd;
  logic [NFWD-1:0]        fwd_avail;
  logic [NFWD*XLEN-1:0]   fwd_data;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [NSRC*XLEN-1:0]   op_data;
  logic [NSRC*SrcW-1:0]   op_src;
  logic                   stall;
  logic [15:0]            stall_cnt;

  modport master (
    output in_valid, rs_addr, rf_data, fwd_valid, fwd_rd, fwd_avail, fwd_data, flush, out_ready,
    input  in_ready, out_valid, op_data, op_src, stall, stall_cnt
  );

  modport slave (
    input  in_valid, rs_addr, rf_data, fwd_valid, fwd_rd, fwd_avail, fwd_data, flush, out_ready,
    output in_ready, out_valid, op_data, op_src, stall, stall_cnt
  );
endinterface

// File: rtl/alu_operand_fwd.sv
// Operand forwarding unit: picks each source operand from the youngest matching pipeline stage
// or the register file, stalls on unavailable results and registers the resolved set.
module alu_operand_fwd #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NSRC = 2,
  parameter int unsigned NFWD = 3,
  parameter int unsigned RAW  = 5
) (
  input logic              clk,
  input logic              rst_n,
  alu_operand_fwd_if.slave bus
);
  localparam int unsigned SrcW = ($clog2(NFWD + 1) > 2) ? $clog2(NFWD + 1) : 2;

  logic [NSRC*XLEN-1:0] op_data_q, op_data_d, sel_data;
  logic [NSRC*SrcW-1:0] op_src_q, op_src_d, sel_src;
  logic                 out_valid_q, out_valid_d;
  logic [15:0]          stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0]      chan_res;
  logic [RAW-1:0]       addr;
  logic                 found;
  logic                 all_res;
  logic                 accept;
  logic                 stall;

  // Youngest match wins; an unavailable youngest match blocks the channel (no older fallback).
  always_comb begin
    sel_data = '0;
    sel_src  = '0;
    chan_res = '1;
    addr     = '0;
    found    = 1'b0;
    for (int c = 0; c < NSRC; c++) begin
      addr  = bus.rs_addr[c*RAW +: RAW];
      found = 1'b0;
      sel_data[c*XLEN +: XLEN] = bus.rf_data[c*XLEN +: XLEN];
      for (int k = 0; k < NFWD; k++) begin
        if (!found && bus.fwd_valid[k] && (addr != '0) && (bus.fwd_rd[k*RAW +: RAW] == addr)) begin
          found                    = 1'b1;
          sel_data[c*XLEN +: XLEN] = bus.fwd_data[k*XLEN +: XLEN];
          sel_src[c*SrcW +: SrcW]  = SrcW'(k + 1);
          chan_res[c]              = bus.fwd_avail[k];
        end
      end
    end
  end

  assign all_res      = &chan_res;
  assign stall        = bus.in_valid & ~all_res;
  // rst_n gates in_ready so nothing is offered as accepted while reset is held.
  assign bus.in_ready = rst_n & all_res & (~out_valid_q | bus.out_ready) & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    op_data_d   = op_data_q;
    op_src_d    = op_src_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      op_data_d   = sel_data;
      op_src_d    = sel_src;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_data_q   <= '0;
      op_src_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op_data_q   <= op_data_d;
      op_src_q    <= op_src_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.op_data   = op_data_q;
  assign bus.op_src    = op_src_q;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_alu_operand_fwd.sv
// Self-checking bench for alu_operand_fwd: vector table, directed corner sequences and random
// traffic, all compared against a behavioural model of the forwarding rules.
module tb_alu_operand_fwd;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NSRC = 2;
  localparam int unsigned NFWD = 3;
  localparam int unsigned RAW  = 5;
  localparam int unsigned SW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_operand_fwd_if #(.XLEN(XLEN), .NSRC(NSRC), .NFWD(NFWD), .RAW(RAW)) bus ();

  alu_operand_fwd #(.XLEN(XLEN), .NSRC(NSRC), .NFWD(NFWD), .RAW(RAW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b1;

  logic            mvalid;
  logic [XLEN-1:0] mdata [NSRC];
  logic [SW-1:0]   msrc  [NSRC];
  int              mcnt;

  typedef struct {
    logic [RAW-1:0]       rs0, rs1;
    logic [XLEN-1:0]      rf0, rf1;
    logic [NFWD-1:0]      fv, fav;
    logic [NFWD*RAW-1:0]  frd;
    logic [NFWD*XLEN-1:0] fdata;
    bit                   ready;
    logic [XLEN-1:0]      d0, d1;
    logic [SW-1:0]        s0, s1;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Spec rule: among valid stages writing this (non-zero) register, the youngest is chosen.
  function automatic void resolve(input int c, output logic [XLEN-1:0] d, output logic [SW-1:0] s,
                                  output bit res);
    logic [RAW-1:0] a;
    int q[$];
    a   = bus.rs_addr[c*RAW +: RAW];
    d   = bus.rf_data[c*XLEN +: XLEN];
    s   = '0;
    res = 1'b1;
    if (a != 0) begin
      for (int k = 0; k < NFWD; k++)
        if (bus.fwd_valid[k] && bus.fwd_rd[k*RAW +: RAW] == a) q.push_back(k);
      if (q.size() > 0) begin
        d   = bus.fwd_data[q[0]*XLEN +: XLEN];
        s   = SW'(q[0] + 1);
        res = bus.fwd_avail[q[0]];
      end
    end
  endfunction

  task automatic model_reset();
    mvalid = 1'b0;
    mcnt   = 0;
    for (int c = 0; c < NSRC; c++) begin
      mdata[c] = '0;
      msrc[c]  = '0;
    end
  endtask

  task automatic check_out();
    check("out_valid", bus.out_valid, mvalid);
    for (int c = 0; c < NSRC; c++) begin
      check($sformatf("op_data%0d", c), bus.op_data[c*XLEN +: XLEN], mdata[c]);
      check($sformatf("op_src%0d", c), bus.op_src[c*SW +: SW], msrc[c]);
    end
    check("stall_cnt", bus.stall_cnt, mcnt);
  endtask

  // Inputs are stable from posedge+1; check combinational outputs, clock, update model, check state.
  task automatic step();
    logic [XLEN-1:0] d [NSRC];
    logic [SW-1:0]   s [NSRC];
    bit r, all_res, exp_ready, exp_stall;
    #1;
    all_res = 1'b1;
    for (int c = 0; c < NSRC; c++) begin
      resolve(c, d[c], s[c], r);
      all_res &= r;
    end
    exp_ready = rst_n && all_res && (!mvalid || bus.out_ready) && !bus.flush;
    exp_stall = bus.in_valid && !all_res;
    if (check_en) begin
      check("in_ready", bus.in_ready, exp_ready);
      check("stall", bus.stall, exp_stall);
    end
    @(posedge clk);
    if (rst_n) begin
      if (exp_stall && mcnt < 65535) mcnt++;
      if (bus.flush) mvalid = 1'b0;
      else if (bus.in_valid && exp_ready) begin
        mvalid = 1'b1;
        for (int c = 0; c < NSRC; c++) begin
          mdata[c] = d[c];
          msrc[c]  = s[c];
        end
      end else if (bus.out_ready) mvalid = 1'b0;
    end
    #1;
    if (check_en) check_out();
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    bus.rs_addr   = '0;
    bus.rf_data   = '0;
    bus.fwd_valid = '0;
    bus.fwd_rd    = '0;
    bus.fwd_avail = '1;
    bus.fwd_data  = '0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input logic [RAW-1:0] rs0, rs1, input logic [XLEN-1:0] rf0, rf1,
                         input logic [NFWD-1:0] fv, fav, input logic [NFWD*RAW-1:0] frd,
                         input logic [NFWD*XLEN-1:0] fdata, input bit ready,
                         input logic [XLEN-1:0] d0, input logic [SW-1:0] s0,
                         input logic [XLEN-1:0] d1, input logic [SW-1:0] s1);
    vec_t v;
    v.rs0 = rs0; v.rs1 = rs1; v.rf0 = rf0; v.rf1 = rf1; v.fv = fv; v.fav = fav;
    v.frd = frd; v.fdata = fdata; v.ready = ready;
    v.d0 = d0; v.s0 = s0; v.d1 = d1; v.s1 = s1;
    tbl.push_back(v);
  endtask

  initial begin
    idle();
    model_reset();
    bus.in_valid = 1'b1;
    #3;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_op_data", bus.op_data, '0);
    check("rst_op_src", bus.op_src, '0);
    check("rst_stall_cnt", bus.stall_cnt, 16'd0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();

    // rs0, rs1, rf0, rf1, fwd_valid, fwd_avail, {rd2,rd1,rd0}, {d2,d1,d0}, ready, exp d0/s0/d1/s1
    add_vec(5, 3, 32'h1234, 32'h3333, 3'b011, 3'b111, {5'd0, 5'd5, 5'd5},
            {32'h0, 32'h1111, 32'hAAAA_0000}, 1, 32'hAAAA_0000, 1, 32'h3333, 0);
    add_vec(0, 0, 32'h0, 32'h55, 3'b001, 3'b111, {5'd0, 5'd0, 5'd0},
            {32'h0, 32'h0, 32'hDEAD}, 1, 32'h0, 0, 32'h55, 0);
    add_vec(9, 9, 32'h1, 32'h2, 3'b100, 3'b111, {5'd9, 5'd0, 5'd0},
            {32'hCCCC, 32'h0, 32'h0}, 1, 32'hCCCC, 3, 32'hCCCC, 3);
    add_vec(7, 1, 32'h1, 32'h2, 3'b011, 3'b110, {5'd0, 5'd7, 5'd7},
            {32'h0, 32'hBBBB, 32'hEEEE}, 0, 32'h0, 0, 32'h0, 0);
    add_vec(4, 6, 32'h1, 32'h2, 3'b011, 3'b111, {5'd0, 5'd6, 5'd4},
            {32'h0, 32'h6666, 32'h4444}, 1, 32'h4444, 1, 32'h6666, 2);
    add_vec(8, 8, 32'h80, 32'h81, 3'b000, 3'b111, {5'd8, 5'd8, 5'd8},
            {32'h1, 32'h2, 32'h3}, 1, 32'h80, 0, 32'h81, 0);
    add_vec(2, 10, 32'h1, 32'h2, 3'b110, 3'b101, {5'd10, 5'd10, 5'd0},
            {32'h9, 32'h8, 32'h7}, 0, 32'h0, 0, 32'h0, 0);

    foreach (tbl[i]) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.rs_addr   = {tbl[i].rs1, tbl[i].rs0};
      bus.rf_data   = {tbl[i].rf1, tbl[i].rf0};
      bus.fwd_valid = tbl[i].fv;
      bus.fwd_avail = tbl[i].fav;
      bus.fwd_rd    = tbl[i].frd;
      bus.fwd_data  = tbl[i].fdata;
      #1;
      check($sformatf("tbl%0d_ready", i), bus.in_ready, tbl[i].ready);
      step();
      if (tbl[i].ready) begin
        check($sformatf("tbl%0d_valid", i), bus.out_valid, 1'b1);
        check($sformatf("tbl%0d_d0", i), bus.op_data[0 +: XLEN], tbl[i].d0);
        check($sformatf("tbl%0d_s0", i), bus.op_src[0 +: SW], tbl[i].s0);
        check($sformatf("tbl%0d_d1", i), bus.op_data[XLEN +: XLEN], tbl[i].d1);
        check($sformatf("tbl%0d_s1", i), bus.op_src[SW +: SW], tbl[i].s1);
      end
    end

    // Load-use: stage 0 result for x7 arrives two cycles late.
    idle();
    reset_pulse();
    bus.in_valid     = 1'b1;
    bus.rs_addr      = {5'd7, 5'd0};
    bus.fwd_valid    = 3'b001;
    bus.fwd_rd[4:0]  = 5'd7;
    bus.fwd_avail    = 3'b000;
    bus.fwd_data     = {32'h0, 32'h0, 32'h7777_0000};
    for (int i = 0; i < 2; i++) begin
      #1;
      check("lu_stall", bus.stall, 1'b1);
      check("lu_not_ready", bus.in_ready, 1'b0);
      step();
    end
    bus.fwd_avail = 3'b001;
    #1;
    check("lu_ready", bus.in_ready, 1'b1);
    step();
    check("lu_valid", bus.out_valid, 1'b1);
    check("lu_data", bus.op_data[XLEN +: XLEN], 32'h7777_0000);
    check("lu_src", bus.op_src[SW +: SW], 2'd1);
    check("lu_stall_cnt", bus.stall_cnt, 16'd2);

    // Backpressure then back-to-back accepts.
    idle();
    bus.in_valid = 1'b1;
    bus.rs_addr  = {5'd0, 5'd3};
    bus.rf_data  = {32'h0, 32'hA0};
    step();
    bus.out_ready = 1'b0;
    bus.rf_data   = {32'h0, 32'hA1};
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_not_ready", bus.in_ready, 1'b0);
      step();
      check("bp_hold", bus.op_data[0 +: XLEN], 32'hA0);
      check("bp_valid", bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rf_data = {32'h0, 32'hB0 + 32'(i)};
      step();
      check("b2b_valid", bus.out_valid, 1'b1);
      check("b2b_data", bus.op_data[0 +: XLEN], 32'hB0 + 32'(i));
    end

    // Flush beats a simultaneous accept and drain.
    bus.flush   = 1'b1;
    bus.rf_data = {32'h0, 32'hC0};
    #1;
    check("flush_not_ready", bus.in_ready, 1'b0);
    step();
    check("flush_valid", bus.out_valid, 1'b0);
    check("flush_hold", bus.op_data[0 +: XLEN], 32'hB3);
    bus.flush = 1'b0;

    // Asynchronous reset while a result is pending.
    bus.rf_data = {32'h0, 32'hD0};
    step();
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_stall_cnt", bus.stall_cnt, 16'd0);
    check("arst_data", bus.op_data, '0);
    check("arst_ready", bus.in_ready, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.rf_data   = {32'h0, 32'hE0};
    step();
    check("first_accept_valid", bus.out_valid, 1'b1);
    check("first_accept_data", bus.op_data[0 +: XLEN], 32'hE0);

    // Saturation of the stall counter.
    idle();
    reset_pulse();
    bus.in_valid    = 1'b1;
    bus.rs_addr     = {5'd0, 5'd5};
    bus.fwd_valid   = 3'b001;
    bus.fwd_rd[4:0] = 5'd5;
    bus.fwd_avail   = 3'b000;
    check_en = 1'b0;
    repeat (65534) step();
    check_en = 1'b1;
    step();
    check("sat_reach", bus.stall_cnt, 16'hFFFF);
    repeat (5) step();
    check("sat_nowrap", bus.stall_cnt, 16'hFFFF);

    // Random traffic against the model.
    idle();
    reset_pulse();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < NSRC; c++) begin
        bus.rs_addr[c*RAW +: RAW]  = RAW'($urandom_range(0, 3));
        bus.rf_data[c*XLEN +: XLEN] = $urandom;
      end
      bus.fwd_valid = NFWD'($urandom);
      for (int k = 0; k < NFWD; k++) begin
        bus.fwd_rd[k*RAW +: RAW]    = RAW'($urandom_range(0, 3));
        bus.fwd_avail[k]            = ($urandom_range(0, 3) != 0);
        bus.fwd_data[k*XLEN +: XLEN] = $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
